// File: rtl/sha256_compression_core.sv
`default_nettype none
// ============================================================================
// Module   : sha256_compression_core
// Purpose  : SHA-256 compression engine. Consumes one scheduled word W[t]
//            per accepted cycle, runs the 64 rounds on working variables
//            a..h, folds the result into H and chains H across blocks.
//            The digest is flagged valid after the last block of a message.
// Ports    : clk, rst (async, active-high)
//            init_i        start a new message (reload H_INIT, abort block)
//            w_valid_i     w_in_i carries W[t]
//            w_in_i[31:0]  scheduled word
//            last_block_i  sampled with W[0]; 1 = final block
//            w_ready_o     word accepted when w_valid_i & w_ready_o
//            busy_o        block partially consumed
//            block_done_o  one-cycle pulse after H has been updated
//            hash_valid_o  digest_o holds the final hash
//            digest_o      H0..H7, H0 in [255:224]
// Revision : 1.0 - initial release
// ============================================================================
module sha256_compression_core #(
  parameter logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_i,
  input  logic         w_valid_i,
  input  logic [31:0]  w_in_i,
  input  logic         last_block_i,
  output logic         w_ready_o,
  output logic         busy_o,
  output logic         block_done_o,
  output logic         hash_valid_o,
  output logic [255:0] digest_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUND  = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [31:0] C_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state_q;
  logic [5:0]  t_q;
  logic        last_q;
  logic [31:0] h_q  [8];   // chaining value H0..H7
  logic [31:0] wv_q [8];   // working variables a..h (index 0 = a)
  logic        w_ready_q;
  logic        busy_q;
  logic        block_done_q;
  logic        hash_valid_q;

  logic        xfer_d;
  logic [31:0] t1_d;
  logic [31:0] t2_d;
  logic [31:0] round_d [8];
  logic [31:0] hsum_d  [8];

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // One compression round on a..h; t_q is 0 in IDLE so the same path serves round 0.
  always_comb begin
    xfer_d = w_valid_i & w_ready_q;
    t1_d   = wv_q[7] + big_sigma1(wv_q[4]) + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
           + C_K[t_q] + w_in_i;
    t2_d   = big_sigma0(wv_q[0]) + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
    round_d[0] = t1_d + t2_d;
    round_d[1] = wv_q[0];
    round_d[2] = wv_q[1];
    round_d[3] = wv_q[2];
    round_d[4] = wv_q[3] + t1_d;
    round_d[5] = wv_q[4];
    round_d[6] = wv_q[5];
    round_d[7] = wv_q[6];
    for (int i = 0; i < 8; i++) begin
      hsum_d[i] = h_q[i] + wv_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      t_q          <= 6'd0;
      last_q       <= 1'b0;
      w_ready_q    <= 1'b1;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      hash_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= H_INIT[255-32*i -: 32];
        wv_q[i] <= H_INIT[255-32*i -: 32];
      end
    end else begin
      block_done_q <= 1'b0;
      if (init_i) begin
        // init overrides any transfer in the same cycle and drops a partial block
        state_q      <= S_IDLE;
        t_q          <= 6'd0;
        last_q       <= 1'b0;
        w_ready_q    <= 1'b1;
        busy_q       <= 1'b0;
        hash_valid_q <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          h_q[i]  <= H_INIT[255-32*i -: 32];
          wv_q[i] <= H_INIT[255-32*i -: 32];
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (xfer_d) begin
              for (int i = 0; i < 8; i++) wv_q[i] <= round_d[i];
              last_q  <= last_block_i;
              t_q     <= 6'd1;
              state_q <= S_ROUND;
              busy_q  <= 1'b1;
            end
          end
          S_ROUND: begin
            if (xfer_d) begin
              for (int i = 0; i < 8; i++) wv_q[i] <= round_d[i];
              t_q <= t_q + 6'd1;   // wraps to 0 after round 63, ready for the next block
              if (t_q == 6'd63) begin
                state_q   <= S_UPDATE;
                w_ready_q <= 1'b0;
                busy_q    <= 1'b0;
              end
            end
          end
          S_UPDATE: begin
            // a..h restart from the new H so IDLE can begin the next block directly
            for (int i = 0; i < 8; i++) begin
              h_q[i]  <= hsum_d[i];
              wv_q[i] <= hsum_d[i];
            end
            block_done_q <= 1'b1;
            if (last_q) begin
              state_q      <= S_DONE;
              hash_valid_q <= 1'b1;
            end else begin
              state_q   <= S_IDLE;
              w_ready_q <= 1'b1;
            end
          end
          default: begin
            // DONE: hold everything until init
          end
        endcase
      end
    end
  end

  assign w_ready_o    = w_ready_q;
  assign busy_o       = busy_q;
  assign block_done_o = block_done_q;
  assign hash_valid_o = hash_valid_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_digest
    assign digest_o[255-32*gi -: 32] = h_q[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_compression_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_compression_core
// Purpose  : Self-checking bench for sha256_compression_core. Scenario tasks
//            drive W streams produced by a behavioural SHA-256 model
//            (schedule + compression computed with plain arrays) and compare
//            handshake, pulses and digests against it and known answers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_compression_core;

  localparam logic [255:0] C_H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] C_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] C_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] C_KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         init = 1'b0;
  logic         w_valid = 1'b0;
  logic [31:0]  w_in = 32'd0;
  logic         last_block = 1'b0;
  logic         w_ready;
  logic         busy;
  logic         block_done;
  logic         hash_valid;
  logic [255:0] digest;

  int n_checks = 0;
  int n_errors = 0;
  int bd_count = 0;

  logic [511:0] c_abc_msg;
  logic [511:0] c_two1_msg;
  logic [511:0] c_two2_msg;

  sha256_compression_core dut (
    .clk          (clk),
    .rst          (rst),
    .init_i       (init),
    .w_valid_i    (w_valid),
    .w_in_i       (w_in),
    .last_block_i (last_block),
    .w_ready_o    (w_ready),
    .busy_o       (busy),
    .block_done_o (block_done),
    .hash_valid_o (hash_valid),
    .digest_o     (digest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (block_done === 1'b1) bd_count++;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message block (word 0 in MSBs) -> 64-word schedule, W[t] at bits [32t +: 32]
  function automatic logic [2047:0] expand(input logic [511:0] m);
    logic [31:0]   w [64];
    logic [2047:0] p;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[511-32*t -: 32];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      p[32*t +: 32] = w[t];
    end
    return p;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [2047:0] wp);
    logic [31:0]  v [8];
    logic [31:0]  x1, x2;
    logic [255:0] hout;
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + C_KT[t] + wp[32*t +: 32];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return hout;
  endfunction

  // ---------------- stimulus ----------------
  // Entered and left just after a falling edge. Feeds nwords words with up to
  // maxgap idle cycles before each; when a full block is sent, checks the
  // UPDATE cycle and the completion cycle.
  task automatic feed(input logic [2047:0] wp, input bit last, input int maxgap,
                      input bit hold, input int nwords);
    for (int t = 0; t < nwords; t++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        w_valid = 1'b0; w_in = $urandom; last_block = 1'($urandom);
        @(negedge clk);
        if (t > 0) begin
          n_checks++;
          if (busy !== 1'b1 || w_ready !== 1'b1 || block_done !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_state t=%0d: busy=%b w_ready=%b block_done=%b, need 1 1 0", t, busy, w_ready, block_done);
          end
        end
      end
      w_valid = 1'b1; w_in = wp[32*t +: 32];
      last_block = (t == 0) ? last : 1'($urandom);
      @(negedge clk);
    end
    if (nwords == 64) begin
      if (!hold) w_valid = 1'b0;
      n_checks++;
      if (w_ready !== 1'b0 || busy !== 1'b0 || block_done !== 1'b0 || hash_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL update_cycle: w_ready=%b busy=%b block_done=%b hash_valid=%b, need 0 0 0 0", w_ready, busy, block_done, hash_valid);
      end
      @(negedge clk);
      n_checks++;
      if (block_done !== 1'b1 || hash_valid !== last || w_ready !== !last || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL block_end: block_done=%b hash_valid=%b w_ready=%b busy=%b, need 1 %b %b 0", block_done, hash_valid, w_ready, busy, last, !last);
      end
      @(negedge clk);
      n_checks++;
      if (block_done !== 1'b0) begin
        n_errors++;
        $display("FAIL block_done_pulse: block_done=%b, need 0", block_done);
      end
    end
  endtask

  task automatic do_init();
    init = 1'b1; w_valid = 1'b0;
    @(negedge clk);
    init = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (w_ready !== 1'b1 || busy !== 1'b0 || block_done !== 1'b0 || hash_valid !== 1'b0 || digest !== C_H0) begin
      n_errors++;
      $display("FAIL reset_values: w_ready=%b busy=%b bd=%b hv=%b digest=%h, need 1 0 0 0 %h", w_ready, busy, block_done, hash_valid, digest, C_H0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abc();
    do_init();
    feed(expand(c_abc_msg), 1'b1, 0, 1'b0, 64);
    n_checks++;
    if (digest !== C_ABC) begin
      n_errors++;
      $display("FAIL abc_digest: got %h need %h", digest, C_ABC);
    end
  endtask

  task automatic test_two_block();
    int bd0;
    do_init();
    bd0 = bd_count;
    feed(expand(c_two1_msg), 1'b0, 0, 1'b0, 64);
    n_checks++;
    if (digest !== compress(C_H0, expand(c_two1_msg)) || hash_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL two_block_mid: digest=%h hv=%b, need %h 0", digest, hash_valid, compress(C_H0, expand(c_two1_msg)));
    end
    feed(expand(c_two2_msg), 1'b1, 0, 1'b0, 64);
    n_checks++;
    if (digest !== C_TWO || bd_count - bd0 != 2) begin
      n_errors++;
      $display("FAIL two_block_digest: got %h pulses=%0d need %h pulses=2", digest, bd_count - bd0, C_TWO);
    end
  endtask

  task automatic test_gaps();
    do_init();
    feed(expand(c_abc_msg), 1'b1, 5, 1'b0, 64);
    n_checks++;
    if (digest !== C_ABC) begin
      n_errors++;
      $display("FAIL gaps_digest: got %h need %h", digest, C_ABC);
    end
  endtask

  task automatic test_init_abort();
    int bd0;
    logic [511:0] m;
    do_init();
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    bd0 = bd_count;
    feed(expand(m), 1'b1, 2, 1'b0, 30);
    init = 1'b1; w_valid = 1'b1; w_in = $urandom;
    @(negedge clk);
    init = 1'b0; w_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || w_ready !== 1'b1 || digest !== C_H0 || block_done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_state: busy=%b w_ready=%b digest=%h bd=%b, need 0 1 %h 0", busy, w_ready, digest, block_done, C_H0);
    end
    feed(expand(c_abc_msg), 1'b1, 0, 1'b0, 64);
    n_checks++;
    if (digest !== C_ABC || bd_count - bd0 != 1) begin
      n_errors++;
      $display("FAIL abort_digest: got %h pulses=%0d need %h pulses=1", digest, bd_count - bd0, C_ABC);
    end
  endtask

  task automatic test_async_rst();
    do_init();
    feed(expand(c_abc_msg), 1'b1, 0, 1'b0, 20);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_round_busy: got %b need 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (w_ready !== 1'b1 || busy !== 1'b0 || block_done !== 1'b0 || hash_valid !== 1'b0 || digest !== C_H0) begin
      n_errors++;
      $display("FAIL async_rst: w_ready=%b busy=%b bd=%b hv=%b digest=%h, need 1 0 0 0 %h", w_ready, busy, block_done, hash_valid, digest, C_H0);
    end
    @(negedge clk);
    rst = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    feed(expand(c_abc_msg), 1'b1, 0, 1'b0, 64);
    n_checks++;
    if (digest !== C_ABC) begin
      n_errors++;
      $display("FAIL after_rst_digest: got %h need %h", digest, C_ABC);
    end
  endtask

  task automatic test_done_hold();
    do_init();
    feed(expand(c_abc_msg), 1'b1, 0, 1'b1, 64);
    for (int k = 0; k < 5; k++) begin
      w_valid = 1'b1; w_in = $urandom; last_block = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (w_ready !== 1'b0 || busy !== 1'b0 || hash_valid !== 1'b1 || digest !== C_ABC) begin
        n_errors++;
        $display("FAIL done_hold: w_ready=%b busy=%b hv=%b digest=%h, need 0 0 1 %h", w_ready, busy, hash_valid, digest, C_ABC);
      end
    end
    init = 1'b1;
    @(negedge clk);
    init = 1'b0; w_valid = 1'b0;
    n_checks++;
    if (w_ready !== 1'b1 || hash_valid !== 1'b0 || digest !== C_H0) begin
      n_errors++;
      $display("FAIL done_init: w_ready=%b hv=%b digest=%h, need 1 0 %h", w_ready, hash_valid, digest, C_H0);
    end
  endtask

  task automatic test_random();
    logic [511:0]  m;
    logic [2047:0] wp;
    logic [255:0]  h;
    int            nb;
    for (int r = 0; r < 4; r++) begin
      nb = int'($urandom_range(3, 1));
      do_init();
      h = C_H0;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
        wp = expand(m);
        h  = compress(h, wp);
        feed(wp, b == nb - 1, 3, 1'b0, 64);
        n_checks++;
        if (digest !== h) begin
          n_errors++;
          $display("FAIL random_digest r=%0d b=%0d: got %h need %h", r, b, digest, h);
        end
      end
    end
  endtask

  initial begin
    c_abc_msg  = {32'h61626380, 448'd0, 32'h00000018};
    c_two1_msg = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    c_two2_msg = {480'd0, 32'h000001c0};
    @(negedge clk);
    test_reset();
    test_abc();
    test_two_block();
    test_gaps();
    test_init_abort();
    test_async_rst();
    test_done_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
